// File: rtl/local_pattern_table.sv
// Local-history pattern table of saturating counters with a registered update
// stage, a clear sweep and optional predict/update forwarding (LPT_BYPASS_EN).
module local_pattern_table #(
  parameter int unsigned IDX_W    = 10,
  parameter int unsigned CTR_W    = 3,
  parameter int unsigned INIT_CTR = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             pred_valid,
  input  logic [IDX_W-1:0] pred_idx,
  output logic             pred_rsp_valid,
  output logic [CTR_W-1:0] pred_ctr,
  output logic             pred_taken,
  input  logic             upd_valid,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken,
  input  logic             clear,
  output logic             busy
);

  localparam int unsigned      DEPTH    = 2 ** IDX_W;
  localparam logic [CTR_W-1:0] CMAX     = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0] INIT     = CTR_W'(INIT_CTR);
  localparam logic [CTR_W-1:0] HALF     = CTR_W'(2 ** (CTR_W - 1));
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic {
    S_IDLE,
    S_CLEAR
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] clr_idx;

  logic [CTR_W-1:0] ctr_tab [DEPTH];

  logic             upd_v_q;
  logic [IDX_W-1:0] upd_idx_q;
  logic             upd_taken_q;

  logic             rmw_en;
  logic [CTR_W-1:0] rmw_old;
  logic [CTR_W-1:0] rmw_new;
  logic [CTR_W-1:0] rd_val;

  // Read-modify-write of the staged update; saturates at both ends.
  always_comb begin
    rmw_en  = upd_v_q && (state == S_IDLE);
    rmw_old = ctr_tab[upd_idx_q];
    rmw_new = rmw_old;
    if (upd_taken_q) begin
      if (rmw_old != CMAX) rmw_new = rmw_old + CTR_W'(1);
    end else begin
      if (rmw_old != '0) rmw_new = rmw_old - CTR_W'(1);
    end
  end

  // Predict read: forwarding returns the value being written this cycle.
  always_comb begin
`ifdef LPT_BYPASS_EN
    if (rmw_en && (pred_idx == upd_idx_q)) rd_val = rmw_new;
    else                                   rd_val = ctr_tab[pred_idx];
`else
    rd_val = ctr_tab[pred_idx];
`endif
  end

  // Counter storage: clear sweep has priority, RMW only while idle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) ctr_tab[i] <= INIT;
    end else if (state == S_CLEAR) begin
      ctr_tab[clr_idx] <= INIT;
    end else if (rmw_en) begin
      ctr_tab[upd_idx_q] <= rmw_new;
    end
  end

  // Update stage; anything arriving with or during a sweep is dropped.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      upd_v_q     <= 1'b0;
      upd_idx_q   <= '0;
      upd_taken_q <= 1'b0;
    end else begin
      upd_v_q     <= upd_valid && (state == S_IDLE) && !clear;
      upd_idx_q   <= upd_idx;
      upd_taken_q <= upd_taken;
    end
  end

  // Clear sweep FSM.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      clr_idx <= '0;
      busy    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (clear) begin
            state   <= S_CLEAR;
            clr_idx <= '0;
            busy    <= 1'b1;
          end
        end
        S_CLEAR: begin
          if (clear) begin
            clr_idx <= '0;
          end else if (clr_idx == LAST_IDX) begin
            state   <= S_IDLE;
            clr_idx <= '0;
            busy    <= 1'b0;
          end else begin
            clr_idx <= clr_idx + IDX_W'(1);
          end
        end
        default: begin
          state   <= S_IDLE;
          clr_idx <= '0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  // Predict response register; a sweeping table reads as INIT everywhere.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pred_rsp_valid <= 1'b0;
      pred_ctr       <= '0;
      pred_taken     <= 1'b0;
    end else begin
      pred_rsp_valid <= pred_valid;
      if (pred_valid) begin
        if (state == S_CLEAR) begin
          pred_ctr   <= INIT;
          pred_taken <= (INIT >= HALF);
        end else begin
          pred_ctr   <= rd_val;
          pred_taken <= (rd_val >= HALF);
        end
      end
    end
  end

endmodule

// File: tb/tb_local_pattern_table.sv
// Self-checking bench for local_pattern_table: vector table of update runs plus
// sequences for collision, clear sweep and reset mid-sweep; predicts scoreboarded.
module tb_local_pattern_table;

`ifdef LPT_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic       pred_valid;
  logic [9:0] pred_idx;
  logic       pred_rsp_valid;
  logic [2:0] pred_ctr;
  logic       pred_taken;
  logic       upd_valid;
  logic [9:0] upd_idx;
  logic       upd_taken;
  logic       clear;
  logic       busy;

  local_pattern_table #(.IDX_W(10), .CTR_W(3), .INIT_CTR(0)) dut (
    .clock(clock), .reset(reset),
    .pred_valid(pred_valid), .pred_idx(pred_idx),
    .pred_rsp_valid(pred_rsp_valid), .pred_ctr(pred_ctr), .pred_taken(pred_taken),
    .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken),
    .clear(clear), .busy(busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [2:0] ctr;
    logic       tk;
  } exp_t;

  typedef struct {
    logic [9:0] idx;
    int         n;
    logic       taken;
    logic [2:0] ctr;
    logic       tk;
  } vec_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   busy_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One cycle: sample outputs at the falling edge, then drive the next inputs.
  task automatic step(input logic pv, input logic [9:0] pidx, input logic uv,
                      input logic [9:0] uidx, input logic ut, input logic clr,
                      input logic [2:0] exp_ctr);
    exp_t e;
    @(negedge clock);
    if (busy) busy_cnt++;
    if (q.size() > 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      tests++;
      if (!pred_rsp_valid || pred_ctr != e.ctr || pred_taken != e.tk) begin
        fails++;
        $display("FAIL predict@%0d: got valid=%0b ctr=%0d taken=%0b expected valid=1 ctr=%0d taken=%0b",
                 cyc, pred_rsp_valid, pred_ctr, pred_taken, e.ctr, e.tk);
      end
    end else if (pred_rsp_valid) begin
      tests++;
      fails++;
      $display("FAIL spurious_rsp@%0d: got valid=1 expected valid=0", cyc);
    end
    pred_valid = pv;
    pred_idx   = pidx;
    upd_valid  = uv;
    upd_idx    = uidx;
    upd_taken  = ut;
    clear      = clr;
    if (pv) begin
      e.cyc = cyc + 1;
      e.ctr = exp_ctr;
      e.tk  = (exp_ctr >= 3'd4);
      q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 10'd0, 1'b0, 10'd0, 1'b0, 1'b0, 3'd0);
  endtask

  task automatic upd(input logic [9:0] idx, input logic t, input int n);
    for (int i = 0; i < n; i++) step(1'b0, 10'd0, 1'b1, idx, t, 1'b0, 3'd0);
  endtask

  task automatic pred(input logic [9:0] idx, input logic [2:0] exp_ctr);
    step(1'b1, idx, 1'b0, 10'd0, 1'b0, 1'b0, exp_ctr);
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{idx: 10'd5,   n: 9, taken: 1'b1, ctr: 3'd7, tk: 1'b1};
    vecs[1] = '{idx: 10'd5,   n: 9, taken: 1'b0, ctr: 3'd0, tk: 1'b0};
    vecs[2] = '{idx: 10'd12,  n: 4, taken: 1'b1, ctr: 3'd4, tk: 1'b1};
    vecs[3] = '{idx: 10'd12,  n: 1, taken: 1'b0, ctr: 3'd3, tk: 1'b0};
    vecs[4] = '{idx: 10'h3FF, n: 3, taken: 1'b1, ctr: 3'd3, tk: 1'b0};
    vecs[5] = '{idx: 10'h3FF, n: 2, taken: 1'b1, ctr: 3'd5, tk: 1'b1};
    vecs[6] = '{idx: 10'd12,  n: 5, taken: 1'b1, ctr: 3'd7, tk: 1'b1};
    vecs[7] = '{idx: 10'd0,   n: 1, taken: 1'b0, ctr: 3'd0, tk: 1'b0};

    reset = 1'b1; pred_valid = 1'b0; pred_idx = '0; upd_valid = 1'b0;
    upd_idx = '0; upd_taken = 1'b0; clear = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    chk("reset_rsp_valid", int'(pred_rsp_valid), 0);
    chk("reset_ctr", int'(pred_ctr), 0);
    chk("reset_taken", int'(pred_taken), 0);
    chk("reset_busy", int'(busy), 0);
    pred(10'h3FF, 3'd0);
    idle(2);

    // Vector table: run of back-to-back updates, then predict two cycles later.
    for (int v = 0; v < 8; v++) begin
      upd(vecs[v].idx, vecs[v].taken, vecs[v].n);
      idle(1);
      pred(vecs[v].idx, vecs[v].ctr);
      idle(1);
      chk($sformatf("vec%0d_taken", v), int'(pred_taken), int'(vecs[v].tk));
    end

    // Predict colliding with an in-flight RMW.
    upd(10'd7, 1'b1, 3);
    idle(1);
    upd(10'd7, 1'b1, 1);
    pred(10'd7, BYP ? 3'd4 : 3'd3);
    idle(1);
    pred(10'd7, 3'd4);
    idle(2);

    // Clear sweep with updates and predicts during it.
    upd(10'd20, 1'b1, 6);
    idle(1);
    pred(10'd20, 3'd6);
    idle(1);
    busy_cnt = 0;
    step(1'b0, 10'd0, 1'b1, 10'd20, 1'b1, 1'b1, 3'd0);
    for (int i = 0; i < 1100; i++) begin
      step(i == 2 || i == 500, (i == 2) ? 10'd12 : 10'd20,
           (i < 100) && (i % 10 == 0), 10'd20, 1'b1, 1'b0, 3'd0);
    end
    chk("sweep_busy_cycles", busy_cnt, 1024);
    chk("sweep_busy_end", int'(busy), 0);
    pred(10'd20, 3'd0);
    pred(10'd12, 3'd0);
    idle(2);

    // Reset in the middle of a sweep.
    upd(10'd1000, 1'b1, 5);
    upd(10'd30, 1'b1, 2);
    idle(1);
    pred(10'd1000, 3'd5);
    idle(1);
    step(1'b0, 10'd0, 1'b0, 10'd0, 1'b0, 1'b1, 3'd0);
    idle(300);
    chk("midsweep_busy", int'(busy), 1);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("reset_busy_immediate", int'(busy), 0);
    chk("reset_rsp_immediate", int'(pred_rsp_valid), 0);
    idle(1);
    reset = 1'b0;
    step(1'b1, 10'd1000, 1'b1, 10'd30, 1'b1, 1'b0, 3'd0);
    pred(10'd600, 3'd0);
    pred(10'd30, 3'd1);
    idle(3);
    chk("scoreboard_drained", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
